// File: rtl/vrf_pkg.sv
// Shared types and defaults for the vector register file.
// Lane helpers keep the lane-0-in-LSBs packing in one place.
package vrf_pkg;

  localparam int unsigned VRF_LANES  = 4;
  localparam int unsigned VRF_LANE_W = 32;
  localparam int unsigned VRF_NREGS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_t;

  function automatic int unsigned lane_lsb(
    input int unsigned lane,
    input int unsigned lane_w
  );
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/vrf_clear_fsm.sv
// Bulk-clear sequencer: walks every register index once,
// then raises a single-cycle done pulse.
module vrf_clear_fsm
  import vrf_pkg::*;
#(
  parameter int unsigned NREGS = VRF_NREGS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req_i,
  output logic                     clr_busy_o,
  output logic                     clr_done_o,
  output logic                     clr_we_o,
  output logic [$clog2(NREGS)-1:0] clr_idx_o
);

  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NREGS - 1);

  clr_state_t       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_busy_o = 1'b1;
        cnt_d      = cnt_q + IDX_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        clr_done_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_we_o  = clr_busy_o;
  assign clr_idx_o = cnt_q;

endmodule

// File: rtl/vector_register_file.sv
// Multi-lane vector register file: 2 read ports with write
// bypass and top-index override, masked write, bulk clear.
module vector_register_file
  import vrf_pkg::*;
#(
  parameter int unsigned LANES       = VRF_LANES,
  parameter int unsigned LANE_W      = VRF_LANE_W,
  parameter int unsigned NREGS       = VRF_NREGS,
  parameter bit          OVERRIDE_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [$clog2(NREGS)-1:0]  wa,
  input  logic [LANES*LANE_W-1:0]   wd,
  input  logic [LANES-1:0]          wmask,
  input  logic [$clog2(NREGS)-1:0]  ra1,
  input  logic [$clog2(NREGS)-1:0]  ra2,
  output logic [LANES*LANE_W-1:0]   rd1,
  output logic [LANES*LANE_W-1:0]   rd2,
  input  logic [LANE_W-1:0]         ovr_data,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic                      wr_drop
);

  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam int unsigned VW    = LANES * LANE_W;
  localparam logic [IDX_W-1:0] TOP = IDX_W'(NREGS - 1);

  logic [VW-1:0]    rf_q [NREGS];
  logic [VW-1:0]    rf_d [NREGS];
  logic             wr_drop_q;
  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;
  logic             ext_we;

  vrf_clear_fsm #(
    .NREGS(NREGS)
  ) u_clr (
    .clk       (clk),
    .rst_n     (reset),
    .clr_req_i (clr_req),
    .clr_busy_o(clr_busy),
    .clr_done_o(clr_done),
    .clr_we_o  (clr_we),
    .clr_idx_o (clr_idx)
  );

  // External writes are shut out for the whole clear sweep.
  assign ext_we = we && !clr_busy;

  always_comb begin
    rf_d = rf_q;
    if (clr_we) begin
      rf_d[clr_idx] = '0;
    end else if (ext_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (wmask[l]) begin
          rf_d[wa][lane_lsb(l, LANE_W) +: LANE_W] =
            wd[lane_lsb(l, LANE_W) +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_q      <= '{default: '0};
      wr_drop_q <= 1'b0;
    end else begin
      rf_q      <= rf_d;
      wr_drop_q <= we && clr_busy;
    end
  end

  assign wr_drop = wr_drop_q;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [IDX_W-1:0] ra_p;
    logic [VW-1:0]    rd_p;

    assign ra_p = (p == 0) ? ra1 : ra2;

    always_comb begin
      rd_p = rf_q[ra_p];
      if (OVERRIDE_EN && ra_p == TOP) begin
        rd_p = {LANES{ovr_data}};
      end else if (ext_we && wa == ra_p) begin
        for (int l = 0; l < LANES; l++) begin
          if (wmask[l]) begin
            rd_p[lane_lsb(l, LANE_W) +: LANE_W] =
              wd[lane_lsb(l, LANE_W) +: LANE_W];
          end
        end
      end
    end
  end

  assign rd1 = g_rd[0].rd_p;
  assign rd2 = g_rd[1].rd_p;

endmodule

// File: tb/tb_vector_register_file.sv
// Self-checking bench for vector_register_file: directed
// scenarios followed by randomized traffic against a model.
module tb_vector_register_file;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int NREGS  = 8;
  localparam int VW     = LANES * LANE_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [2:0]    wa;
  logic [VW-1:0] wd;
  logic [3:0]    wmask;
  logic [2:0]    ra1;
  logic [2:0]    ra2;
  logic [VW-1:0] rd1;
  logic [VW-1:0] rd2;
  logic [31:0]   ovr_data;
  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;
  logic          wr_drop;

  always #5 clk = ~clk;

  vector_register_file #(
    .LANES      (LANES),
    .LANE_W     (LANE_W),
    .NREGS      (NREGS),
    .OVERRIDE_EN(1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .wmask   (wmask),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .ovr_data(ovr_data),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .wr_drop (wr_drop)
  );

  // Reference model: register contents per lane, plus the
  // number of registers still waiting to be cleared.
  logic [31:0] m_rf [NREGS][LANES];
  int          m_left;
  bit          m_done;
  bit          m_drop;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          busy_cnt;
  int          done_cnt;

  function automatic logic [VW-1:0] exp_rd(input logic [2:0] ra);
    logic [VW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*32 +: 32] = m_rf[ra][l];
    if (ra == 3'(NREGS - 1)) begin
      for (int l = 0; l < LANES; l++) v[l*32 +: 32] = ovr_data;
    end else if (we && m_left == 0 && wa == ra) begin
      for (int l = 0; l < LANES; l++)
        if (wmask[l]) v[l*32 +: 32] = wd[l*32 +: 32];
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs,
                     input logic [VW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("clr_busy", VW'(clr_busy), VW'(m_left > 0));
    chk("clr_done", VW'(clr_done), VW'(m_done));
    chk("wr_drop", VW'(wr_drop), VW'(m_drop));
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++)
      for (int l = 0; l < LANES; l++) m_rf[r][l] = '0;
    m_left = 0;
    m_done = 0;
    m_drop = 0;
  endtask

  task automatic model_edge();
    bit busy;
    bit nd;
    busy = (m_left > 0);
    nd   = 0;
    if (we && !busy)
      for (int l = 0; l < LANES; l++)
        if (wmask[l]) m_rf[wa][l] = wd[l*32 +: 32];
    if (busy) begin
      for (int l = 0; l < LANES; l++) m_rf[NREGS - m_left][l] = '0;
      if (m_left == 1) nd = 1;
      m_left--;
    end else if (!m_done && clr_req) begin
      m_left = NREGS;
    end
    m_drop = we && busy;
    m_done = nd;
  endtask

  task automatic cycle();
    #1;
    check_all();
    if (reset) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_all();
    for (int r = 0; r < NREGS; r++) begin
      we    = 1'b1;
      wa    = 3'(r);
      wmask = 4'hF;
      for (int l = 0; l < LANES; l++) wd[l*32 +: 32] = $urandom | 32'h1;
      cycle();
    end
    we = 1'b0;
  endtask

  task automatic count_clear(input int ncyc);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      ra1 = 3'(i);
      ra2 = 3'(i + 1);
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      cycle();
    end
  endtask

  initial begin
    reset    = 1'b0;
    we       = 1'b0;
    wa       = '0;
    wd       = '0;
    wmask    = '0;
    ra1      = 3'd0;
    ra2      = 3'd7;
    ovr_data = 32'h108;
    clr_req  = 1'b0;
    model_reset();

    @(posedge clk);
    #1;
    chk("rst_rd1", rd1, '0);
    chk("rst_ovr", rd2, {4{32'h108}});
    chk("rst_busy", VW'(clr_busy), '0);
    chk("rst_done", VW'(clr_done), '0);
    chk("rst_drop", VW'(wr_drop), '0);
    reset = 1'b1;
    cycle();

    // full-mask write then read back
    we    = 1'b1;
    wa    = 3'd2;
    wd    = {32'hD, 32'hC, 32'hB, 32'hA};
    wmask = 4'hF;
    cycle();
    we  = 1'b0;
    ra1 = 3'd2;
    #1;
    chk("t1_rd1", rd1, {32'hD, 32'hC, 32'hB, 32'hA});
    cycle();

    // masked write with same-cycle bypass
    we    = 1'b1;
    wa    = 3'd3;
    wd    = {4{32'h11}};
    wmask = 4'hF;
    cycle();
    wd    = {4{32'h22}};
    wmask = 4'b0101;
    ra2   = 3'd3;
    #1;
    chk("t2_bypass", rd2, {32'h11, 32'h22, 32'h11, 32'h22});
    cycle();
    we = 1'b0;
    #1;
    chk("t2_stored", rd2, {32'h11, 32'h22, 32'h11, 32'h22});
    cycle();

    // override wins over bypass
    ovr_data = 32'h108;
    we       = 1'b1;
    wa       = 3'd7;
    wd       = {4{32'hFF}};
    wmask    = 4'hF;
    ra1      = 3'd7;
    #1;
    chk("t3_ovr", rd1, {4{32'h108}});
    cycle();
    we = 1'b0;
    #1;
    chk("t3_ovr_after", rd1, {4{32'h108}});
    cycle();

    // full clear sweep
    fill_all();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    count_clear(12);
    chk("t4_busy_cycles", VW'(busy_cnt), VW'(8));
    chk("t4_done_pulses", VW'(done_cnt), VW'(1));
    for (int r = 0; r < NREGS - 1; r++) begin
      ra1 = 3'(r);
      #1;
      chk("t4_zero", rd1, '0);
      cycle();
    end

    // write attempted during clear is dropped
    fill_all();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cycle();
    we    = 1'b1;
    wa    = 3'd5;
    wd    = {4{32'h5A5A5A5A}};
    wmask = 4'hF;
    ra1   = 3'd5;
    cycle();
    we = 1'b0;
    #1;
    chk("t5_drop", VW'(wr_drop), VW'(1));
    for (int i = 0; i < 10; i++) cycle();
    ra1 = 3'd5;
    #1;
    chk("t5_zero", rd1, '0);
    cycle();

    // reset in the middle of a clear
    fill_all();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cycle();
    cycle();
    cycle();
    chk("t6_pre_busy", VW'(clr_busy), VW'(1));
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_busy_drop", VW'(clr_busy), '0);
    chk("t6_no_done", VW'(clr_done), '0);
    for (int r = 0; r < 4; r++) begin
      ra1 = 3'(2 * r);
      ra2 = 3'(2 * r + 1);
      cycle();
    end
    reset   = 1'b1;
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    count_clear(12);
    chk("t6_busy_cycles", VW'(busy_cnt), VW'(8));
    chk("t6_done_pulses", VW'(done_cnt), VW'(1));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      we    = 1'($urandom_range(0, 1));
      wa    = 3'($urandom);
      wmask = 4'($urandom);
      for (int l = 0; l < LANES; l++) wd[l*32 +: 32] = $urandom;
      ra1      = 3'($urandom);
      ra2      = ($urandom_range(0, 1) == 1) ? wa : 3'($urandom);
      ovr_data = $urandom;
      clr_req  = ($urandom_range(0, 31) == 0);
      cycle();
    end
    we      = 1'b0;
    clr_req = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
